// File: rtl/dut.sv
// -----------------------------------------------------------------------------
// dut -- WIDTH-bit D-type register with synchronous, active-high reset.
//
// Each rising edge of clk loads Q with the value D held just before that edge.
// With rst high on an edge, Q loads RST_VAL instead, whatever D is.
// The register has no enable. Q comes straight from the flop, so there is no
// combinational path from D or rst to Q.
//
// Parameters
//   WIDTH    data width of D and Q
//   RST_VAL  value loaded into Q by a reset edge
//
// Ports
//   clk  in   single clock, rising-edge active
//   rst  in   synchronous reset, active high, takes priority over D
//   D    in   data to capture
//   Q    out  registered data, one clock after D
// -----------------------------------------------------------------------------
module dut #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next-state value. Reset wins over data on the same edge.
    always_comb begin
        q_d = D;
        if (rst) begin
            q_d = RST_VAL;
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values
    //       of its inputs, which also lets a D written with <= on the same edge
    //       be picked up one edge later.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: tb/tb_dut.sv
// -----------------------------------------------------------------------------
// tb_dut -- self-checking bench for the dut register.
//
// Each scenario runs in its own task, and the tasks run in order from one
// initial block. Expected values come from a behavioural rule: after an edge,
// Q is RST_VAL if rst was high at that edge, otherwise the D held at that edge.
// In the random scenario, a queue of expected values is checked against every
// change on Q.
// -----------------------------------------------------------------------------
module tb_dut;

    localparam int unsigned WIDTH   = 4;
    localparam logic [3:0]  RST_VAL = 4'h0;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    int total;
    int bad;

    // Counts every change on Q, including changes between clock edges.
    int q_events;

    // Expected values for the random scenario. The monitor pops one entry
    // each time Q changes.
    logic [WIDTH-1:0] exp_q[$];
    bit               mon_en;

    dut #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .D  (D),
        .Q  (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(Q) begin
        q_events = q_events + 1;
        if (mon_en) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL rand_unexpected_change: Q=%h with no expected value queued at %0t", Q, $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (Q !== e) begin
                    bad = bad + 1;
                    $display("FAIL rand_q_change: Q=%h expected %h at %0t", Q, e, $time);
                end
            end
        end
    end

    // Stops the run if a task ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        D   = 4'hA;
        @(posedge clk);
        #1;
        total++;
        if (Q !== RST_VAL) begin
            bad++;
            $display("FAIL reset_load: Q=%h expected %h", Q, RST_VAL);
        end
        @(negedge clk);
        rst = 1'b0;
        D   = 4'h5;
        @(posedge clk);
        #1;
        total++;
        if (Q !== 4'h5) begin
            bad++;
            $display("FAIL reset_release: Q=%h expected %h", Q, 4'h5);
        end
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 4'h3;
        vals[1] = 4'h7;
        vals[2] = 4'hC;
        vals[3] = 4'hF;
        // D is written with <= on the edge, so that edge still sees the old D (5).
        @(posedge clk);
        D <= vals[0];
        #1;
        total++;
        if (Q !== 4'h5) begin
            bad++;
            $display("FAIL latency_same_edge: Q=%h expected %h", Q, 4'h5);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            if (i < 4) D <= vals[i];
            #1;
            total++;
            if (Q !== vals[i-1]) begin
                bad++;
                $display("FAIL latency_%0d: Q=%h expected %h", i, Q, vals[i-1]);
            end
        end
    endtask

    task automatic test_glitch();
        int ev;
        @(negedge clk);
        D = 4'h2;
        @(posedge clk);
        #1;
        total++;
        if (Q !== 4'h2) begin
            bad++;
            $display("FAIL glitch_setup: Q=%h expected %h", Q, 4'h2);
        end
        ev = q_events;
        @(negedge clk);
        #1 D = 4'h9;
        #1;
        total++;
        if (Q !== 4'h2) begin
            bad++;
            $display("FAIL glitch_mid: Q=%h expected %h", Q, 4'h2);
        end
        D = 4'h2;
        @(posedge clk);
        #1;
        total++;
        if (Q !== 4'h2 || q_events != ev) begin
            bad++;
            $display("FAIL glitch_hold: Q=%h expected %h, events=%0d expected %0d",
                     Q, 4'h2, q_events - ev, 0);
        end
    endtask

    task automatic test_narrow_reset();
        @(negedge clk);
        D = 4'h6;
        @(posedge clk);
        #1;
        total++;
        if (Q !== 4'h6) begin
            bad++;
            $display("FAIL narrow_setup: Q=%h expected %h", Q, 4'h6);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (Q !== 4'h6) begin
            bad++;
            $display("FAIL narrow_reset: Q=%h expected %h", Q, 4'h6);
        end
    endtask

    task automatic test_reset_in_stream();
        logic [WIDTH-1:0] ds  [3];
        logic             rs  [3];
        logic [WIDTH-1:0] exp;
        ds[0] = 4'h1; rs[0] = 1'b0;
        ds[1] = 4'h2; rs[1] = 1'b1;
        ds[2] = 4'h3; rs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            D   = ds[i];
            rst = rs[i];
            exp = rs[i] ? RST_VAL : ds[i];
            @(posedge clk);
            #1;
            total++;
            if (Q !== exp) begin
                bad++;
                $display("FAIL stream_%0d: Q=%h expected %h", i, Q, exp);
            end
        end
    endtask

    task automatic test_reset_held();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1;
            D   = WIDTH'($urandom_range(1, 15));
            @(posedge clk);
            #1;
            total++;
            if (Q !== RST_VAL) begin
                bad++;
                $display("FAIL reset_held_%0d: Q=%h expected %h", i, Q, RST_VAL);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        D   = 4'hB;
        @(posedge clk);
        #1;
        total++;
        if (Q !== 4'hB) begin
            bad++;
            $display("FAIL reset_held_release: Q=%h expected %h", Q, 4'hB);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] model;
        logic [WIDTH-1:0] d;
        model  = 4'hB;
        mon_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d = WIDTH'($urandom);
            D = d;
            // Q changes only when the captured value differs from the current one.
            if (d != model) begin
                exp_q.push_back(d);
                model = d;
            end
            @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        total++;
        if (exp_q.size() != 0 || Q !== model) begin
            bad++;
            $display("FAIL rand_final: Q=%h expected %h, unmatched=%0d expected 0",
                     Q, model, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        q_events = 0;
        mon_en   = 1'b0;
        rst      = 1'b0;
        D        = '0;
        test_reset();
        test_latency();
        test_glitch();
        test_narrow_reset();
        test_reset_in_stream();
        test_reset_held();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
